// File: rtl/wb_accel_bridge_pkg.sv
// Shared types for the accelerator Wishbone bridge: FSM state encoding,
// the latched request record and the stats-window slot helper.
package optimsoc_accel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP,
        ERR
    } accel_bridge_state_t;

    // One latched master request, as forwarded to the selected slave
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_req_t;

    // The highest slot value is reserved for the statistics window
    function automatic int STATS_SLOT(input int slot_bits);
        return (1 << slot_bits) - 1;
    endfunction

endpackage

// File: rtl/wb_accel_bridge_if.sv
// Master-side Wishbone bus of the accelerator bridge. Signal names keep the
// bridge's own port naming so they read the same on both sides.
interface wb_accel_bridge_if;

    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic [31:0] wbs_dat_o;

    // Network adapter side
    modport master (
        output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        input  wbs_ack_o, wbs_err_o, wbs_dat_o
    );

    // Bridge side
    modport slave (
        input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_cyc_i, wbs_stb_i,
        output wbs_ack_o, wbs_err_o, wbs_dat_o
    );

endinterface

// File: rtl/wb_accel_bridge_stats.sv
// Transaction statistics for the accelerator bridge: per-slave saturating
// ack counters, a saturating timeout counter and the read mux of the stats
// window. Only built when OPTIMSOC_ACCEL_BRIDGE_STATS_EN is defined.
module wb_accel_bridge_stats #(
    parameter int NR_ACCEL = 2,
    parameter int SLOT_LSB = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NR_ACCEL-1:0] ack_inc_i,
    input  logic                timeout_inc_i,
    input  logic                clear_i,
    input  logic [SLOT_LSB-1:0] offset_i,
    output logic [31:0]         rdata_o
);

    logic [NR_ACCEL-1:0][31:0] ack_cnt_q, ack_cnt_d;
    logic [31:0]               to_cnt_q, to_cnt_d;

    // Saturating increments; a clear overrides any same-cycle completion
    always_comb begin
        ack_cnt_d = ack_cnt_q;
        to_cnt_d  = to_cnt_q;
        if (clear_i) begin
            ack_cnt_d = '0;
            to_cnt_d  = '0;
        end else begin
            for (int i = 0; i < NR_ACCEL; i++) begin
                if (ack_inc_i[i] && ack_cnt_q[i] != '1) begin
                    ack_cnt_d[i] = ack_cnt_q[i] + 32'd1;
                end
            end
            if (timeout_inc_i && to_cnt_q != '1) begin
                to_cnt_d = to_cnt_q + 32'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            ack_cnt_q <= ack_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    // Word-offset read mux; unknown offsets read zero
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NR_ACCEL; i++) begin
            if (offset_i == SLOT_LSB'(4 * i)) begin
                rdata_o = ack_cnt_q[i];
            end
        end
        if (offset_i == SLOT_LSB'(4 * NR_ACCEL)) begin
            rdata_o = to_cnt_q;
        end
    end

endmodule

// File: rtl/wb_accel_bridge.sv
// Wishbone bridge from the network adapter master to NR_ACCEL accelerator
// slaves. The slot field of the address selects one slave; one transaction
// is in flight at a time. Unmapped slots and slave errors answer with
// wbs_err_o, a watchdog aborts silent slaves, and a dropped wbs_cyc_i
// abandons the transfer without a response.
// Optional: OPTIMSOC_ACCEL_BRIDGE_STATS_EN maps the top slot to a
// statistics window (wb_accel_bridge_stats); otherwise that slot errors.
module wb_accel_bridge
    import optimsoc_accel_pkg::*;
#(
    parameter int NR_ACCEL  = 2,
    parameter int SLOT_LSB  = 24,
    parameter int SLOT_BITS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    wb_accel_bridge_if.slave          wbs,
    output logic [NR_ACCEL-1:0][31:0] acc_adr_o,
    output logic [NR_ACCEL-1:0][31:0] acc_dat_o,
    output logic [NR_ACCEL-1:0][3:0]  acc_sel_o,
    output logic [NR_ACCEL-1:0]       acc_we_o,
    output logic [NR_ACCEL-1:0]       acc_cyc_o,
    output logic [NR_ACCEL-1:0]       acc_stb_o,
    input  logic [NR_ACCEL-1:0]       acc_ack_i,
    input  logic [NR_ACCEL-1:0]       acc_err_i,
    input  logic [NR_ACCEL-1:0][31:0] acc_dat_i,
    output logic                      timeout_o
);

    accel_bridge_state_t       state_q, state_d;
    wb_req_t [NR_ACCEL-1:0]    req_q, req_d;    // per-slave forwarded request, zero when not selected
    logic [NR_ACCEL-1:0]       sel_q, sel_d;    // one-hot active slave, drives cyc and stb
    logic [15:0]               cnt_q, cnt_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic                      to_q, to_d;
    logic [31:0]               dat_q, dat_d;

    logic [SLOT_BITS-1:0]      slot;
    wb_req_t                   req_in;
    logic                      hit_ack, hit_err;
    logic [31:0]               hit_dat;

    assign slot   = wbs.wbs_adr_i[SLOT_LSB+SLOT_BITS-1:SLOT_LSB];
    assign req_in = '{adr: wbs.wbs_adr_i, dat: wbs.wbs_dat_i,
                      sel: wbs.wbs_sel_i, we: wbs.wbs_we_i};

`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
    logic [NR_ACCEL-1:0] st_ack_inc;
    logic                st_to_inc;
    logic                st_clr;
    logic [31:0]         st_rdata;

    wb_accel_bridge_stats #(
        .NR_ACCEL (NR_ACCEL),
        .SLOT_LSB (SLOT_LSB)
    ) u_stats (
        .clk           (clk),
        .rst           (rst),
        .ack_inc_i     (st_ack_inc),
        .timeout_inc_i (st_to_inc),
        .clear_i       (st_clr),
        .offset_i      (wbs.wbs_adr_i[SLOT_LSB-1:0]),
        .rdata_o       (st_rdata)
    );
`endif

    // Response of the currently selected slave
    always_comb begin
        hit_ack = |(acc_ack_i & sel_q);
        hit_err = |(acc_err_i & sel_q);
        hit_dat = '0;
        for (int i = 0; i < NR_ACCEL; i++) begin
            if (sel_q[i]) begin
                hit_dat = acc_dat_i[i];
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
        st_ack_inc = '0;
        st_to_inc  = 1'b0;
        st_clr     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
                    if (int'(slot) == STATS_SLOT(SLOT_BITS)) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        dat_d   = st_rdata;
                        st_clr  = wbs.wbs_we_i;
                    end else
`endif
                    if (int'(slot) < NR_ACCEL) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                        for (int i = 0; i < NR_ACCEL; i++) begin
                            if (int'(slot) == i) begin
                                sel_d[i] = 1'b1;
                                req_d[i] = req_in;
                            end
                        end
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // Priority: master abort, slave error, slave ack, watchdog
                if (!wbs.wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (hit_err) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else if (hit_ack) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    dat_d   = hit_dat;
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
                    st_ack_inc = sel_q;
`endif
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
                    st_to_inc = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (state_d != ACTIVE) begin
                    sel_d = '0;
                    req_d = '0;
                end
            end
            RESP, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            to_q    <= to_d;
            dat_q   <= dat_d;
        end
    end

    // Flop outputs onto the ports
    always_comb begin
        for (int i = 0; i < NR_ACCEL; i++) begin
            acc_adr_o[i] = req_q[i].adr;
            acc_dat_o[i] = req_q[i].dat;
            acc_sel_o[i] = req_q[i].sel;
            acc_we_o[i]  = req_q[i].we;
        end
    end

    assign acc_cyc_o     = sel_q;
    assign acc_stb_o     = sel_q;
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_err_o = err_q;
    assign wbs.wbs_dat_o = dat_q;
    assign timeout_o     = to_q;

endmodule

// File: tb/tb_wb_accel_bridge.sv
// Self-checking bench for wb_accel_bridge: directed scenarios plus random
// transactions, each checked against a cycle-count reference model.
module tb_wb_accel_bridge;

    localparam int NR_ACCEL  = 2;
    localparam int SLOT_LSB  = 24;
    localparam int SLOT_BITS = 4;
    localparam int TIMEOUT   = 8;
    localparam int MAX_CYC   = 40;
    localparam int R_NONE    = 0;
    localparam int R_ACK     = 1;
    localparam int R_ERR     = 2;

    logic clk = 1'b0;
    logic rst;

    wb_accel_bridge_if wbs ();

    logic [NR_ACCEL-1:0][31:0] acc_adr_o, acc_dat_o, acc_dat_i;
    logic [NR_ACCEL-1:0][3:0]  acc_sel_o;
    logic [NR_ACCEL-1:0]       acc_we_o, acc_cyc_o, acc_stb_o, acc_ack_i, acc_err_i;
    logic                      timeout_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model of the statistics counters
    int unsigned ack_cnt [NR_ACCEL];
    int unsigned to_cnt;

    always #5 clk = ~clk;

    wb_accel_bridge #(
        .NR_ACCEL  (NR_ACCEL),
        .SLOT_LSB  (SLOT_LSB),
        .SLOT_BITS (SLOT_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbs       (wbs),
        .acc_adr_o (acc_adr_o),
        .acc_dat_o (acc_dat_o),
        .acc_sel_o (acc_sel_o),
        .acc_we_o  (acc_we_o),
        .acc_cyc_o (acc_cyc_o),
        .acc_stb_o (acc_stb_o),
        .acc_ack_i (acc_ack_i),
        .acc_err_i (acc_err_i),
        .acc_dat_i (acc_dat_i),
        .timeout_o (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] stats_value(input int offset);
        for (int i = 0; i < NR_ACCEL; i++) begin
            if (offset == 4 * i) return ack_cnt[i];
        end
        if (offset == 4 * NR_ACCEL) return to_cnt;
        return 32'h0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NR_ACCEL; i++) ack_cnt[i] = 0;
        to_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wbs"}, {29'b0, wbs.wbs_ack_o, wbs.wbs_err_o, timeout_o}, 32'h0);
        check({tag, ".wbs_dat"}, wbs.wbs_dat_o, 32'h0);
        check({tag, ".acc_ctl"}, {28'b0, acc_cyc_o, acc_stb_o}, 32'h0);
        check({tag, ".acc_req"}, {31'b0, |{acc_adr_o, acc_dat_o, acc_sel_o, acc_we_o}}, 32'h0);
    endtask

    // One complete master transaction, starting and ending at a negedge.
    // k: slave wait states; resp: slave response kind; rdata: slave read data.
    task automatic run_txn(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we, input int k,
                           input int resp, input logic [31:0] rdata);
        int slot, offset;
        int exp_kind, exp_cyc, exp_stb, exp_to;
        logic [31:0] exp_dat;
        logic chk_dat;
        int got_kind, got_cyc, stb_seen, to_seen, extra;
        logic [31:0] got_dat;
        logic path_ok, quiet_ok;

        slot    = int'(adr[SLOT_LSB+SLOT_BITS-1:SLOT_LSB]);
        offset  = int'(adr[SLOT_LSB-1:0]);
        exp_stb = 0;
        exp_to  = 0;
        chk_dat = 1'b0;
        exp_dat = '0;
        if (slot < NR_ACCEL) begin
            if (resp != R_NONE && k + 1 <= TIMEOUT) begin
                exp_kind = resp;
                exp_cyc  = k + 2;
                exp_stb  = k + 1;
                chk_dat  = (resp == R_ACK) && !we;
                exp_dat  = rdata;
            end else begin
                exp_kind = R_ERR;
                exp_cyc  = TIMEOUT + 1;
                exp_stb  = TIMEOUT;
                exp_to   = 1;
            end
        end
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
        else if (slot == (1 << SLOT_BITS) - 1) begin
            exp_kind = R_ACK;
            exp_cyc  = 1;
            chk_dat  = !we;
            exp_dat  = stats_value(offset);
        end
`endif
        else begin
            exp_kind = R_ERR;
            exp_cyc  = 1;
        end

        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        wbs.wbs_we_i  = we;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        got_kind = R_NONE;
        got_cyc  = 0;
        got_dat  = '0;
        stb_seen = 0;
        to_seen  = 0;
        extra    = 0;
        path_ok  = 1'b1;
        quiet_ok = 1'b1;

        for (int n = 1; n <= MAX_CYC; n++) begin
            @(negedge clk);
            for (int i = 0; i < NR_ACCEL; i++) begin
                if (i == slot && acc_stb_o[i]) begin
                    if (acc_adr_o[i] !== adr || acc_dat_o[i] !== dat || acc_sel_o[i] !== sel ||
                        acc_we_o[i] !== we || acc_cyc_o[i] !== 1'b1) path_ok = 1'b0;
                end else if (acc_stb_o[i] || acc_cyc_o[i] || acc_adr_o[i] != 0 ||
                             acc_dat_o[i] != 0 || acc_sel_o[i] != 0 || acc_we_o[i]) begin
                    quiet_ok = 1'b0;
                end
            end
            if (slot < NR_ACCEL && acc_stb_o[slot]) stb_seen++;
            if (timeout_o) to_seen++;
            if (wbs.wbs_ack_o || wbs.wbs_err_o) begin
                if (got_kind == R_NONE) begin
                    got_kind = (wbs.wbs_ack_o && wbs.wbs_err_o) ? 3 : (wbs.wbs_ack_o ? R_ACK : R_ERR);
                    got_cyc  = n;
                    got_dat  = wbs.wbs_dat_o;
                    wbs.wbs_cyc_i = 1'b0;
                    wbs.wbs_stb_i = 1'b0;
                end else begin
                    extra++;
                end
            end
            acc_ack_i = '0;
            acc_err_i = '0;
            for (int i = 0; i < NR_ACCEL; i++) acc_dat_i[i] = $urandom;
            if (got_kind == R_NONE && slot < NR_ACCEL && acc_stb_o[slot] && stb_seen == k + 1) begin
                if (resp == R_ACK) begin
                    acc_ack_i[slot] = 1'b1;
                    acc_dat_i[slot] = rdata;
                end else if (resp == R_ERR) begin
                    acc_err_i[slot] = 1'b1;
                end
            end
            if (got_kind != R_NONE && n >= got_cyc + 2) break;
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        acc_ack_i     = '0;
        acc_err_i     = '0;

        check({tag, ".kind"}, got_kind, exp_kind);
        check({tag, ".cycle"}, got_cyc, exp_cyc);
        check({tag, ".stb_cycles"}, stb_seen, exp_stb);
        check({tag, ".timeout"}, to_seen, exp_to);
        check({tag, ".slave_req"}, {31'b0, path_ok}, 32'h1);
        check({tag, ".others_quiet"}, {31'b0, quiet_ok}, 32'h1);
        check({tag, ".single_resp"}, extra, 0);
        if (chk_dat) check({tag, ".rdata"}, got_dat, exp_dat);

        if (exp_kind == R_ACK && slot < NR_ACCEL && ack_cnt[slot] != 32'hFFFF_FFFF) ack_cnt[slot]++;
        if (exp_to != 0) to_cnt++;
`ifdef OPTIMSOC_ACCEL_BRIDGE_STATS_EN
        if (slot == (1 << SLOT_BITS) - 1 && we) clear_model();
`endif
    endtask

    initial begin
        int resp_cnt;
        rst = 1'b1;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
        wbs.wbs_sel_i = '0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        acc_ack_i = '0;
        acc_err_i = '0;
        acc_dat_i = '0;
        clear_model();

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        run_txn("t1_write_s1", 32'h0100_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, R_ACK, 32'h0);
        run_txn("t2_read_s0", 32'h0000_0004, 32'h0, 4'hF, 1'b0, 3, R_ACK, 32'h1234_5678);
        run_txn("t3_unmapped", 32'h0500_0000, 32'h0, 4'hF, 1'b0, 0, R_ACK, 32'h0);
        run_txn("t4_timeout", 32'h0000_0008, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);
        run_txn("t4_after", 32'h0100_0000, 32'h0, 4'h3, 1'b0, 1, R_ACK, 32'hCAFE_0001);
        run_txn("ack_at_limit", 32'h0000_0000, 32'h0, 4'hF, 1'b0, TIMEOUT - 1, R_ACK, 32'h0BAD_F00D);
        run_txn("slave_err", 32'h0100_0040, 32'h55AA_55AA, 4'h1, 1'b1, 2, R_ERR, 32'h0);

        // Statistics window (error path when the feature is absent)
        run_txn("t6_clear", 32'h0F00_0000, 32'h0, 4'hF, 1'b1, 0, R_NONE, 32'h0);
        for (int i = 0; i < 3; i++)
            run_txn("t6_s1_ack", 32'h0100_0100, $urandom, 4'hF, 1'b1, i, R_ACK, 32'h0);
        run_txn("t6_read_s1", 32'h0F00_0004, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);
        run_txn("t6_read_to", 32'h0F00_0008, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);
        run_txn("t6_clear2", 32'h0F00_0000, 32'h0, 4'hF, 1'b1, 0, R_NONE, 32'h0);
        run_txn("t6_read_s1_0", 32'h0F00_0004, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);

        // Master abort in ACTIVE: slave is released, no response follows
        wbs.wbs_adr_i = 32'h0000_0100;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        repeat (3) @(negedge clk);
        check("abort.stb_before", {30'b0, acc_stb_o}, 32'h1);
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        @(negedge clk);
        check("abort.cyc_drop", {28'b0, acc_cyc_o, acc_stb_o}, 32'h0);
        resp_cnt = 0;
        repeat (4) begin
            if (wbs.wbs_ack_o || wbs.wbs_err_o || timeout_o) resp_cnt++;
            @(negedge clk);
        end
        check("abort.no_resp", resp_cnt, 0);

        // Reset in the middle of ACTIVE
        wbs.wbs_adr_i = 32'h0100_0020;
        wbs.wbs_dat_i = 32'h1357_9BDF;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid.stb_before", {30'b0, acc_stb_o}, 32'h2);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_mid.async");
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid.held");
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        run_txn("post_reset", 32'h0000_0030, 32'h0, 4'hF, 1'b0, 0, R_ACK, 32'hA5A5_0000);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            int r, slot, k, resp;
            logic [31:0] adr;
            logic we;
            r    = $urandom_range(0, 9);
            we   = 1'($urandom_range(0, 1));
            adr  = $urandom;
            if (r <= 3)      slot = 0;
            else if (r <= 6) slot = 1;
            else if (r == 7) slot = $urandom_range(2, 14);
            else if (r == 8) slot = 15;
            else             slot = 1;
            if (slot == 15) begin
                adr[SLOT_LSB-1:0] = SLOT_LSB'(4 * $urandom_range(0, 3));
                we = ($urandom_range(0, 5) == 0);
            end
            adr[SLOT_LSB+SLOT_BITS-1:SLOT_LSB] = SLOT_BITS'(slot);
            k    = $urandom_range(0, 9);
            resp = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0 && resp == R_NONE) resp = R_ACK;
            run_txn("rand", adr, $urandom, 4'($urandom), we, k, resp, $urandom);
        end
        run_txn("rand_stats_s0", 32'h0F00_0000, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);
        run_txn("rand_stats_to", 32'h0F00_0008, 32'h0, 4'hF, 1'b0, 0, R_NONE, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
